// File: rtl/collatz_sweep_if.sv
// Job, core and summary handshake bundle for collatz_sweep.
// slave = the sweep block's view, master = the driving environment's view.
interface collatz_sweep_if #(
   parameter int N     = 16,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_first;
   logic [CNT_W-1:0] in_count;
   logic [N-1:0]     in_step;
   logic             core_in_valid;
   logic             core_in_ready;
   logic [N-1:0]     core_in0;
   logic             core_out_valid;
   logic             core_out_ready;
   logic [N-1:0]     core_out0;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_max;
   logic [N-1:0]     out_arg;
   logic [CNT_W-1:0] out_n;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_first, in_count, in_step,
      input  core_in_ready, core_out_valid, core_out0, out_ready,
      output in_ready, core_in_valid, core_in0, core_out_ready,
      output out_valid, out_max, out_arg, out_n, out_ovf
   );

   modport master (
      output in_valid, in_first, in_count, in_step,
      output core_in_ready, core_out_valid, core_out0, out_ready,
      input  in_ready, core_in_valid, core_in0, core_out_ready,
      input  out_valid, out_max, out_arg, out_n, out_ovf
   );
endinterface

// File: rtl/collatz_sweep.sv
// Issues first, first+step, ... to a collatz core one op at a time and reports max/argmax.
// COLLATZ_SWEEP_OVF_EN: abort with out_ovf when the next start value carries out of N bits.
module collatz_sweep #(
   parameter int N     = 16,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   collatz_sweep_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     cur_q, cur_d, cur_nxt;
   logic [N-1:0]     step_q, step_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [N-1:0]     max_q, max_d;
   logic [N-1:0]     arg_q, arg_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic             in_ready_q, in_ready_d;
   logic             core_in_valid_q, core_in_valid_d;
   logic             core_out_ready_q, core_out_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [N-1:0]     core_in0_q, core_in0_d;

`ifdef COLLATZ_SWEEP_OVF_EN
   logic [N:0]       sum;
   logic             ovf_q, ovf_d;
   assign sum     = {1'b0, cur_q} + {1'b0, step_q};
   assign cur_nxt = sum[N-1:0];
   assign bus.out_ovf = ovf_q;
`else
   assign cur_nxt = cur_q + step_q;
   assign bus.out_ovf = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      step_d  = step_q;
      count_d = count_q;
      max_d   = max_q;
      arg_d   = arg_q;
      n_d     = n_q;
`ifdef COLLATZ_SWEEP_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            // core_out_ready is high here, so stale core results drain away.
            if (bus.in_valid && in_ready_q) begin
               cur_d   = bus.in_first;
               step_d  = bus.in_step;
               count_d = bus.in_count;
               max_d   = '0;
               arg_d   = bus.in_first;
               n_d     = '0;
`ifdef COLLATZ_SWEEP_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = (bus.in_count == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (core_in_valid_q && bus.core_in_ready) state_d = WAIT;
         end
         WAIT: begin
            if (bus.core_out_valid && core_out_ready_q) begin
               n_d   = n_q + CNT_W'(1);
               cur_d = cur_nxt;
               if (bus.core_out0 > max_q) begin
                  max_d = bus.core_out0;
                  arg_d = cur_q;
               end
               if (n_d == count_q) state_d = DONE;
`ifdef COLLATZ_SWEEP_OVF_EN
               else if (sum[N]) begin
                  ovf_d   = 1'b1;
                  state_d = DONE;
               end
`endif
               else state_d = ISSUE;
            end
         end
         DONE: begin
            if (out_valid_q && bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they are flops, not comb.
      in_ready_d       = (state_d == IDLE);
      core_in_valid_d  = (state_d == ISSUE);
      core_out_ready_d = (state_d != ISSUE);
      out_valid_d      = (state_d == DONE);
      core_in0_d       = cur_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         cur_q            <= '0;
         step_q           <= '0;
         count_q          <= '0;
         max_q            <= '0;
         arg_q            <= '0;
         n_q              <= '0;
         in_ready_q       <= 1'b1;
         core_in_valid_q  <= 1'b0;
         core_out_ready_q <= 1'b1;
         out_valid_q      <= 1'b0;
         core_in0_q       <= '0;
`ifdef COLLATZ_SWEEP_OVF_EN
         ovf_q            <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         cur_q            <= cur_d;
         step_q           <= step_d;
         count_q          <= count_d;
         max_q            <= max_d;
         arg_q            <= arg_d;
         n_q              <= n_d;
         in_ready_q       <= in_ready_d;
         core_in_valid_q  <= core_in_valid_d;
         core_out_ready_q <= core_out_ready_d;
         out_valid_q      <= out_valid_d;
         core_in0_q       <= core_in0_d;
`ifdef COLLATZ_SWEEP_OVF_EN
         ovf_q            <= ovf_d;
`endif
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.core_in_valid  = core_in_valid_q;
   assign bus.core_in0       = core_in0_q;
   assign bus.core_out_ready = core_out_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_max        = max_q;
   assign bus.out_arg        = arg_q;
   assign bus.out_n          = n_q;
endmodule

// File: tb/tb_collatz_sweep.sv
// Bench for collatz_sweep with a x3 core model (2-cycle latency, in_ready low one cycle per accept).
// Expected summaries come from a behavioural sweep model and are queued per job.
module tb_collatz_sweep;
   typedef struct packed {
      logic [15:0] mx;
      logic [15:0] arg;
      logic [15:0] n;
      logic        ovf;
   } summ_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   summ_t       exp_q[$];
   logic [15:0] issued[$];
   logic [1:0]  lat;
   logic [15:0] res;

   collatz_sweep_if #(.N(16), .CNT_W(16)) bus ();

   collatz_sweep #(.N(16), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: out0 = in0*3, shares rst with the sweep block.
   always @(posedge clk) begin
      if (rst) begin
         bus.core_in_ready  <= 1'b1;
         bus.core_out_valid <= 1'b0;
         bus.core_out0      <= 16'd0;
         lat                <= 2'd0;
         res                <= 16'd0;
      end else begin
         bus.core_in_ready <= 1'b1;
         if (bus.core_in_valid && bus.core_in_ready) begin
            bus.core_in_ready <= 1'b0;
            res <= bus.core_in0 * 16'd3;
            lat <= 2'd2;
            issued.push_back(bus.core_in0);
         end else if (lat != 2'd0) begin
            lat <= lat - 2'd1;
            if (lat == 2'd1) begin
               bus.core_out_valid <= 1'b1;
               bus.core_out0      <= res;
            end
         end
         if (bus.core_out_valid && bus.core_out_ready) bus.core_out_valid <= 1'b0;
      end
   end

   function automatic summ_t model(input logic [15:0] first, input logic [15:0] count,
                                   input logic [15:0] step);
      summ_t       s;
      logic [15:0] cur;
      logic [15:0] r;
      logic [16:0] nx;
      s.mx = 16'd0; s.arg = first; s.n = 16'd0; s.ovf = 1'b0;
      cur = first;
      for (int i = 0; i < int'(count); i++) begin
         r = cur * 16'd3;
         s.n = s.n + 16'd1;
         if (r > s.mx) begin
            s.mx  = r;
            s.arg = cur;
         end
         nx  = {1'b0, cur} + {1'b0, step};
         cur = nx[15:0];
`ifdef COLLATZ_SWEEP_OVF_EN
         if (nx[16] && (i + 1) < int'(count)) begin
            s.ovf = 1'b1;
            break;
         end
`endif
      end
      return s;
   endfunction

   task automatic send_job(input logic [15:0] first, input logic [15:0] count,
                           input logic [15:0] step);
      int k;
      exp_q.push_back(model(first, count, step));
      bus.in_first = first;
      bus.in_count = count;
      bus.in_step  = step;
      bus.in_valid = 1'b1;
      k = 0;
      while (!bus.in_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic collect(output summ_t got, output bit ok);
      int k;
      k = 0;
      got = '0;
      ok  = 1'b0;
      while (!bus.out_valid && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      if (bus.out_valid) begin
         got = {bus.out_max, bus.out_arg, bus.out_n, bus.out_ovf};
         ok  = 1'b1;
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      logic [52:0] got;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      got = {bus.in_ready, bus.core_in_valid, bus.core_out_ready, bus.out_valid, bus.out_ovf,
             bus.out_max, bus.out_arg, bus.out_n};
      total++;
      if (got !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 48'd0} || bus.core_in0 !== 16'd0) begin
         bad++;
         $display("FAIL reset_values got=%h core_in0=%h exp=%h core_in0=0", got, bus.core_in0,
                  {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 48'd0});
      end
      rst = 1'b0;
   endtask

   task automatic test_single;
      summ_t got, exp;
      bit    ok;
      issued.delete();
      send_job(16'd27, 16'd1, 16'd1);
      collect(got, ok);
      exp = exp_q.pop_front();
      total++;
      if (!ok || got !== exp) begin
         bad++;
         $display("FAIL single_result ok=%0d got=%h exp=%h", ok, got, exp);
      end
      total++;
      if (issued.size() != 1 || issued[0] !== 16'd27) begin
         bad++;
         $display("FAIL single_in0 got_ops=%0d exp_ops=1 exp_in0=27", issued.size());
      end
   endtask

   task automatic test_sweep;
      summ_t       got, exp;
      bit          ok;
      logic [15:0] want [4];
      want = '{16'd10, 16'd15, 16'd20, 16'd25};
      issued.delete();
      send_job(16'd10, 16'd4, 16'd5);
      collect(got, ok);
      exp = exp_q.pop_front();
      total++;
      if (!ok || got !== exp || exp.mx !== 16'd75 || exp.arg !== 16'd25) begin
         bad++;
         $display("FAIL sweep_result ok=%0d got=%h exp=%h (max 75 arg 25)", ok, got, exp);
      end
      total++;
      if (issued.size() != 4) begin
         bad++;
         $display("FAIL sweep_ops got=%0d exp=4", issued.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (issued[i] !== want[i]) begin
               bad++;
               $display("FAIL sweep_in0[%0d] got=%h exp=%h", i, issued[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_count_zero;
      summ_t got, exp;
      bit    ok;
      int    k;
      issued.delete();
      send_job(16'd7, 16'd0, 16'd3);
      k = 1;
      while (!bus.out_valid && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      total++;
      if (!bus.out_valid || k > 2) begin
         bad++;
         $display("FAIL zero_latency got=%0d cycles valid=%b exp<=2 valid=1", k, bus.out_valid);
      end
      collect(got, ok);
      exp = exp_q.pop_front();
      total++;
      if (!ok || got !== exp || exp !== {16'd0, 16'd7, 16'd0, 1'b0}) begin
         bad++;
         $display("FAIL zero_result ok=%0d got=%h exp=%h", ok, got, exp);
      end
      total++;
      if (issued.size() != 0) begin
         bad++;
         $display("FAIL zero_no_core_ops got=%0d exp=0", issued.size());
      end
   endtask

   task automatic test_hold_done;
      summ_t got, exp, snap, now;
      bit    ok;
      int    k, bad_cyc;
      send_job(16'd3, 16'd2, 16'd1);
      k = 0;
      while (!bus.out_valid && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      snap = {bus.out_max, bus.out_arg, bus.out_n, bus.out_ovf};
      bus.in_first = 16'd100;
      bus.in_count = 16'd1;
      bus.in_step  = 16'd1;
      bus.in_valid = 1'b1;
      bad_cyc = 0;
      repeat (20) begin
         now = {bus.out_max, bus.out_arg, bus.out_n, bus.out_ovf};
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || now !== snap) bad_cyc++;
         @(posedge clk); #1;
      end
      total++;
      if (bad_cyc != 0) begin
         bad++;
         $display("FAIL hold_stable got=%0d unstable cycles exp=0", bad_cyc);
      end
      exp = exp_q.pop_front();
      total++;
      if (snap !== exp) begin
         bad++;
         $display("FAIL hold_result got=%h exp=%h", snap, exp);
      end
      bus.in_valid = 1'b0;
      collect(got, ok);
      total++;
      if (!ok || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL hold_in_ready_after ok=%0d got=%b exp=1", ok, bus.in_ready);
      end
      send_job(16'd100, 16'd1, 16'd1);
      collect(got, ok);
      exp = exp_q.pop_front();
      total++;
      if (!ok || got !== exp) begin
         bad++;
         $display("FAIL hold_next_job ok=%0d got=%h exp=%h", ok, got, exp);
      end
   endtask

   task automatic test_reset_mid_job;
      summ_t       got, exp;
      bit          ok;
      int          k;
      logic [52:0] st;
      issued.delete();
      send_job(16'd5, 16'd8, 16'd1);
      void'(exp_q.pop_back());
      k = 0;
      while (issued.size() == 0 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      st = {bus.in_ready, bus.core_in_valid, bus.core_out_ready, bus.out_valid, bus.out_ovf,
            bus.out_max, bus.out_arg, bus.out_n};
      total++;
      if (issued.size() == 0 || st !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 48'd0}
          || bus.core_in0 !== 16'd0) begin
         bad++;
         $display("FAIL midjob_reset ops=%0d got=%h core_in0=%h exp=%h", issued.size(), st,
                  bus.core_in0, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 48'd0});
      end
      rst = 1'b0;
      send_job(16'd1, 16'd2, 16'd1);
      collect(got, ok);
      exp = exp_q.pop_front();
      total++;
      if (!ok || got !== exp || got.mx !== 16'd6 || got.arg !== 16'd2) begin
         bad++;
         $display("FAIL midjob_next ok=%0d got=%h exp=%h (max 6 arg 2)", ok, got, exp);
      end
   endtask

   task automatic test_ovf;
      summ_t got, exp;
      bit    ok;
      int    want_ops;
`ifdef COLLATZ_SWEEP_OVF_EN
      want_ops = 2;
`else
      want_ops = 3;
`endif
      issued.delete();
      send_job(16'hFFFE, 16'd3, 16'd1);
      collect(got, ok);
      exp = exp_q.pop_front();
      total++;
      if (!ok || got !== exp) begin
         bad++;
         $display("FAIL ovf_result ok=%0d got=%h exp=%h", ok, got, exp);
      end
      total++;
      if (issued.size() != want_ops || issued[0] !== 16'hFFFE || issued[1] !== 16'hFFFF
          || (want_ops == 3 && issued[2] !== 16'h0000)) begin
         bad++;
         $display("FAIL ovf_in0 got_ops=%0d exp_ops=%0d", issued.size(), want_ops);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_first  = 16'd0;
      bus.in_count  = 16'd0;
      bus.in_step   = 16'd0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single();
      test_sweep();
      test_count_zero();
      test_hold_done();
      test_reset_mid_job();
      test_ovf();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
